mux_n_rr: RTL and testbench
===========================

# mux_n_rr

Registered, parametrised N-input multiplexer with round-robin arbitration and valid/ready handshakes. It is the next generation of our fixed 4:1 combinational bus mux. It merges CHANNELS independent WIDTH-bit producer streams onto one consumer stream, using a single output register stage. It sits wherever several datapath sources share one downstream sink.

## Interface
Parameters:
- WIDTH, 64, data bits per channel.
- CHANNELS, 4, number of input channels; must be ≥ 2.
- SEL_W, 2, width of the channel index; must equal ceil(log2(CHANNELS)).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  CHANNELS  per-channel valid; bit i belongs to channel i.
- in_data  input  CHANNELS*WIDTH  flattened payloads; channel i occupies bits [i*WIDTH +: WIDTH].
- in_ready  output  CHANNELS  per-channel accept; one-hot or zero.
- out_valid  output  1  output register holds a word.
- out_ready  input  1  consumer accepts the word.
- out_data  output  WIDTH  registered payload.
- out_sel  output  SEL_W  index of the channel that produced out_data.

## Operation
- State: output register (out_valid, out_data, out_sel) and round-robin pointer ptr (SEL_W bits, range 0..CHANNELS-1).
- load = (|in_valid) && (!out_valid || out_ready).
- Grant: the first channel with in_valid set, scanning from ptr upward and wrapping past CHANNELS-1 to 0. grant is one-hot and is zero when no channel is valid.
- in_ready = grant when load is 1; otherwise all zero. in_ready is combinational from in_valid, out_valid, out_ready and ptr.
- A transfer on channel i occurs when in_valid[i] && in_ready[i].
- On load:
  - out_data <= payload of the granted channel.
  - out_sel <= granted index.
  - out_valid <= 1.
  - ptr <= granted index + 1; the value CHANNELS wraps to 0.
- If out_valid && out_ready && !load: out_valid <= 0. out_data and out_sel hold their last values.
- If out_valid && !out_ready: the register holds and all in_ready are 0.
- ptr changes only on load.
- Simultaneous drain and fill (out_ready=1 with a pending input) gives full throughput of one word per cycle. There is no bubble.
- Producers must hold in_valid and in_data stable until accepted. The block does not check this.

## Timing
- Reset values (async, while rst_n=0): out_valid=0, out_data=0, out_sel=0, ptr=0, in_ready=0.
- Reset asserted mid-operation clears all state immediately, and the held word is dropped. The first grant after deassertion scans from channel 0.
- Latency: a word accepted at edge k appears on out_data/out_valid after edge k. That is one cycle, independent of CHANNELS.
- Fairness: with all channels continuously valid and out_ready=1, grants cycle 0,1,…,CHANNELS-1,0. Each channel is served at least once every CHANNELS accepted words.
- Non-contiguous valids: the pointer skips idle channels. For example, with ptr=1 and only channels 0 and 3 valid, channel 3 is granted and ptr becomes 0.

## Configuration
- MUX_N_RR_FIXED_PRIO_EN
  - Defined: fixed-priority arbitration. The lowest-index valid channel always wins, and ptr is neither implemented nor updated.
  - Undefined (default): round-robin behaviour as described above.
- Interface, handshake and latency are identical in both builds.

## Test plan
- Reset: hold rst_n=0 with all in_valid=1 → out_valid=0, out_data=0, out_sel=0, in_ready=4'b0000. Assert rst_n asynchronously mid-cycle → outputs clear without waiting for a clock edge.
- Single channel: in_valid=4'b0100, channel 2 data 64'hA5A5_0000_DEAD_BEEF, out_ready=1 → in_ready=4'b0100. One edge later: out_valid=1, out_data=64'hA5A5_0000_DEAD_BEEF, out_sel=2.
- Round robin: all four valid, distinct data 0x10..0x13, out_ready=1 for 5 cycles → out_sel sequence 0,1,2,3,0, with out_valid=1 every cycle.
- Backpressure: out_valid=1, out_sel=1, out_ready=0 for 3 cycles with in_valid=4'b1111 → in_ready=0 and out_data stable throughout. Raise out_ready → channel 2 is loaded on the next edge.
- Reset mid-stream: during the round-robin stream, after ptr=3, pulse rst_n low → out_valid=0 immediately. After release, the first grant is channel 0.
- With MUX_N_RR_FIXED_PRIO_EN: all valid, out_ready=1 → out_sel=0 on every cycle. Drop in_valid[0] → out_sel=1 on the next load.

Source files
------------

// File: rtl/mux_n_rr.sv
// mux_n_rr: registered CHANNELS:1 mux with round-robin arbitration and valid/ready handshakes.
// Build option MUX_N_RR_FIXED_PRIO_EN: lowest-index valid channel always wins, no rotating pointer.
module mux_n_rr #(
    parameter int WIDTH    = 64,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS-1:0]       in_valid,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    output logic [CHANNELS-1:0]       in_ready,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_sel
);

    function automatic logic [SEL_W-1:0] wrap_idx(input int unsigned v);
        int unsigned w;
        w = v % CHANNELS;
        return w[SEL_W-1:0];
    endfunction

    logic                  out_valid_r;
    logic [WIDTH-1:0]      out_data_r;
    logic [SEL_W-1:0]      out_sel_r;
    logic [SEL_W-1:0]      scan_base_s;
    logic                  found_s;
    logic [SEL_W-1:0]      grant_idx_s;
    logic [CHANNELS-1:0]   grant_s;
    logic [WIDTH-1:0]      grant_data_s;
    logic                  load_s;

`ifdef MUX_N_RR_FIXED_PRIO_EN
    assign scan_base_s = {SEL_W{1'b0}};
`else
    logic [SEL_W-1:0] ptr_r;
    logic [SEL_W-1:0] next_ptr_s;

    assign scan_base_s = ptr_r;

    // Pointer moves just past the granted channel so it has lowest priority next time.
    always_comb begin
        next_ptr_s = (grant_idx_s == SEL_W'(CHANNELS - 1)) ? {SEL_W{1'b0}}
                                                           : grant_idx_s + SEL_W'(1);
    end

    // Round-robin pointer register, updated only when a word is loaded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r <= {SEL_W{1'b0}};
        end else if (load_s) begin
            ptr_r <= next_ptr_s;
        end else begin
            ptr_r <= ptr_r;
        end
    end
`endif

    // First valid channel scanning upward from the scan base, wrapping at CHANNELS.
    always_comb begin
        logic [SEL_W-1:0] cand_v;
        logic             take_v;
        found_s     = 1'b0;
        grant_idx_s = {SEL_W{1'b0}};
        cand_v      = {SEL_W{1'b0}};
        take_v      = 1'b0;
        for (int k = 0; k < CHANNELS; k++) begin
            cand_v      = wrap_idx(int'(scan_base_s) + k);
            take_v      = !found_s && in_valid[cand_v];
            grant_idx_s = take_v ? cand_v : grant_idx_s;
            found_s     = found_s | take_v;
        end
    end

    // One-hot grant vector and the AND-OR selected payload.
    always_comb begin
        grant_s      = {CHANNELS{1'b0}};
        grant_data_s = {WIDTH{1'b0}};
        for (int i = 0; i < CHANNELS; i++) begin
            grant_s[i]   = found_s && (grant_idx_s == SEL_W'(i));
            grant_data_s = grant_data_s | ({WIDTH{grant_s[i]}} & in_data[i*WIDTH +: WIDTH]);
        end
    end

    // Reset gates the handshake so nothing is acknowledged while rst_n is low.
    always_comb begin
        load_s   = rst_n && (|in_valid) && (!out_valid_r || out_ready);
        in_ready = load_s ? grant_s : {CHANNELS{1'b0}};
    end

    // Output register: fill (possibly while draining), drain, or hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            out_data_r  <= {WIDTH{1'b0}};
            out_sel_r   <= {SEL_W{1'b0}};
        end else if (load_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= grant_data_s;
            out_sel_r   <= grant_idx_s;
        end else if (out_valid_r && out_ready) begin
            out_valid_r <= 1'b0;
            out_data_r  <= out_data_r;
            out_sel_r   <= out_sel_r;
        end else begin
            out_valid_r <= out_valid_r;
            out_data_r  <= out_data_r;
            out_sel_r   <= out_sel_r;
        end
    end

    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_sel   = out_sel_r;

endmodule

// File: tb/tb_mux_n_rr.sv
// Self-checking bench for mux_n_rr: directed steps then random traffic against a queue-free reference model.
module tb_mux_n_rr;

    localparam int W = 64;
    localparam int C = 4;
    localparam int S = 2;

`ifdef MUX_N_RR_FIXED_PRIO_EN
    localparam int RR_EXP [7] = '{0, 0, 0, 0, 0, 0, 0};
    localparam int BP_SEL     = 0;
    localparam int RAISE_SEL  = 0;
`else
    localparam int RR_EXP [7] = '{0, 1, 2, 3, 0, 1, 2};
    localparam int BP_SEL     = 1;
    localparam int RAISE_SEL  = 2;
`endif

    logic           clk = 1'b0;
    logic           rst_n;
    logic [C-1:0]   in_valid;
    logic [C*W-1:0] in_data;
    logic [C-1:0]   in_ready;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out_data;
    logic [S-1:0]   out_sel;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state
    logic         m_valid;
    logic [W-1:0] m_data;
    int           m_sel;
    int           m_ptr;

    mux_n_rr #(.WIDTH(W), .CHANNELS(C), .SEL_W(S)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_sel(out_sel)
    );

    always #5 clk = ~clk;

    function automatic int ref_grant(input logic [C-1:0] v, input int p);
        int start;
        start = p;
`ifdef MUX_N_RR_FIXED_PRIO_EN
        start = 0;
`endif
        for (int k = 0; k < C; k++) begin
            int idx;
            idx = (start + k) % C;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic logic [C-1:0] ref_ready();
        logic [C-1:0] r;
        r = '0;
        if (rst_n && in_valid != '0 && (!m_valid || out_ready))
            r[ref_grant(in_valid, m_ptr)] = 1'b1;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "/in_ready"},  64'(in_ready),  64'(ref_ready()));
        chk({tag, "/out_valid"}, 64'(out_valid), 64'(m_valid));
        chk({tag, "/out_data"},  out_data,       m_data);
        chk({tag, "/out_sel"},   64'(out_sel),   64'(m_sel));
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_data  = '0;
        m_sel   = 0;
        m_ptr   = 0;
    endtask

    task automatic tick();
        int   g;
        logic ld;
        g  = ref_grant(in_valid, m_ptr);
        ld = rst_n && (in_valid != '0) && (!m_valid || out_ready);
        @(posedge clk);
        if (ld) begin
            m_data  = in_data[g*W +: W];
            m_sel   = g;
            m_valid = 1'b1;
            m_ptr   = (g + 1) % C;
        end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
        end
        #1;
    endtask

    task automatic rst_pulse(input string tag);
        #3 rst_n = 1'b0;
        #1 model_reset();
        chk({tag, "/valid_clr"}, 64'(out_valid), 64'd0);
        check_all(tag);
        #2 rst_n = 1'b1;
    endtask

    task automatic set_rr_data();
        for (int c = 0; c < C; c++) in_data[c*W +: W] = 64'h10 + 64'(c);
    endtask

    initial begin
        rst_n     = 1'b1;
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        set_rr_data();
        model_reset();

        // Asynchronous reset assertion between edges, then held through edges
        #2 rst_n = 1'b0;
        #1;
        check_all("rst_async");
        #20;
        chk("rst_hold/in_ready", 64'(in_ready), 64'd0);
        check_all("rst_hold");
        in_valid = 4'b0000;
        rst_n    = 1'b1;
        tick();
        check_all("idle");

        // Single channel
        in_valid = 4'b0100;
        in_data[2*W +: W] = 64'hA5A5_0000_DEAD_BEEF;
        #1;
        chk("single/in_ready", 64'(in_ready), 64'h4);
        check_all("single_pre");
        tick();
        chk("single/out_valid", 64'(out_valid), 64'd1);
        chk("single/out_data", out_data, 64'hA5A5_0000_DEAD_BEEF);
        chk("single/out_sel", 64'(out_sel), 64'd2);
        check_all("single_post");

        // Reset while holding a word drops it immediately
        rst_pulse("rst_drop");

        // Round robin with all channels valid
        in_valid = 4'b1111;
        set_rr_data();
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick();
            chk("rr/out_valid", 64'(out_valid), 64'd1);
            chk("rr/out_sel", 64'(out_sel), 64'(RR_EXP[i]));
            chk("rr/out_data", out_data, 64'h10 + 64'(RR_EXP[i]));
            check_all("rr");
        end

        // Reset mid-stream, first grant afterwards is channel 0
        rst_pulse("rst_mid");
        tick();
        chk("rst_first/out_sel", 64'(out_sel), 64'd0);
        check_all("rst_first");
        tick();
        chk("bp_setup/out_sel", 64'(out_sel), 64'(BP_SEL));

        // Backpressure holds the register and blocks all inputs
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp/in_ready", 64'(in_ready), 64'd0);
            tick();
            chk("bp/out_data", out_data, 64'h10 + 64'(BP_SEL));
            chk("bp/out_valid", 64'(out_valid), 64'd1);
            check_all("bp");
        end
        out_ready = 1'b1;
        tick();
        chk("bp_release/out_sel", 64'(out_sel), 64'(RAISE_SEL));
        check_all("bp_release");

        rst_pulse("rst_pre_sparse");
`ifdef MUX_N_RR_FIXED_PRIO_EN
        in_valid = 4'b1110;
        tick();
        chk("fixed_drop0/out_sel", 64'(out_sel), 64'd1);
        check_all("fixed_drop0");
`else
        // Non-contiguous valids: ptr=1, channels 0 and 3 valid -> 3 then 0
        in_valid = 4'b0001;
        tick();
        in_valid = 4'b1001;
        #1;
        chk("sparse/in_ready", 64'(in_ready), 64'h8);
        tick();
        chk("sparse/out_sel3", 64'(out_sel), 64'd3);
        tick();
        chk("sparse/out_sel0", 64'(out_sel), 64'd0);
        check_all("sparse");
`endif

        // Random traffic with occasional asynchronous resets
        for (int it = 0; it < 400; it++) begin
            in_valid  = 4'($urandom_range(0, 15));
            out_ready = ($urandom_range(0, 3) != 0);
            for (int c = 0; c < C; c++) in_data[c*W +: W] = {$urandom(), $urandom()};
            #1;
            check_all("rand_pre");
            if (it % 97 == 96) begin
                rst_pulse("rand_rst");
            end else begin
                tick();
                check_all("rand_post");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
